// File: rtl/scg_rst_seq.sv
// scg_rst_seq: synchronises the clock-core lock flag and releases domain resets in order,
// re-asserting them all on lock loss or soft reset.
module scg_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_WAIT   = 16,
  parameter int N_DOMAINS   = 3,
  parameter int STAGE_GAP   = 4,
  parameter int SOFT_HOLD   = 8,
  parameter int CNT_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 locked_i,
  input  logic                 soft_rst_i,
  output logic [N_DOMAINS-1:0] rst_n_o,
  output logic                 ready_o,
  output logic [2:0]           state_o,
  output logic [CNT_W-1:0]     lock_loss_o
);
  localparam int MAXV = (LOCK_WAIT > STAGE_GAP) ? ((LOCK_WAIT > SOFT_HOLD) ? LOCK_WAIT : SOFT_HOLD)
                                                : ((STAGE_GAP > SOFT_HOLD) ? STAGE_GAP : SOFT_HOLD);
  localparam int CW = $clog2(MAXV + 1);
  typedef enum logic [2:0] {WAIT_LOCK = 3'd0, STABLE = 3'd1, RELEASE = 3'd2, RUN = 3'd3, HOLD = 3'd4} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [N_DOMAINS-1:0]   r_rst_n;
  logic                   r_ready;
  logic [CNT_W-1:0]       r_loss;
  logic                   w_locked_s;
  assign w_locked_s  = r_sync[SYNC_STAGES-1];
  assign rst_n_o     = r_rst_n;
  assign ready_o     = r_ready;
  assign state_o     = r_state;
  assign lock_loss_o = r_loss;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= WAIT_LOCK;
      r_sync  <= '0;
      r_cnt   <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
      r_loss  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked_i};
      case (r_state)
        WAIT_LOCK: begin
          r_cnt <= '0;
          if (w_locked_s) r_state <= STABLE;
        end
        STABLE: begin
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(LOCK_WAIT - 1)) begin
            r_state <= RELEASE;
            r_rst_n <= N_DOMAINS'(1);
            r_cnt   <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        RELEASE, RUN, HOLD: begin
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_rst_n <= '0;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            if (r_loss != {CNT_W{1'b1}}) r_loss <= r_loss + 1'b1;
          end else if (soft_rst_i && r_state != HOLD) begin
            r_state <= HOLD;
            r_rst_n <= '0;
            r_ready <= 1'b0;
            r_cnt   <= '0;
          end else if (r_state == HOLD) begin
            if (r_cnt == CW'(SOFT_HOLD - 1)) begin
              r_state <= RELEASE;
              r_rst_n <= N_DOMAINS'(1);
              r_cnt   <= '0;
            end else r_cnt <= r_cnt + 1'b1;
          end else if (r_state == RELEASE) begin
            // thermometer shift keeps release strictly bit 0 upward
            if (r_cnt == CW'(STAGE_GAP - 1)) begin
              r_cnt <= '0;
              if (&r_rst_n) begin
                r_state <= RUN;
                r_ready <= 1'b1;
              end else r_rst_n <= ~(~r_rst_n << 1);
            end else r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_rst_n <= '0;
          r_ready <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule
